// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN datapath blocks: FSM state encoding,
// output-feature-map sizing and signed saturation.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH,
        DONE
    } state_t;

    localparam int FLUSH_LEN = 2;

    function automatic int ofm_size(input int ifm, input int k);
        return ifm - k + 1;
    endfunction

    // Clamp a sign-extended accumulator value to the signed range of out_w bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/psum_ram.sv
// Simple dual-port partial-sum buffer: one write port, one synchronous read
// port, no reset (contents are don't-care until the first channel overwrites them).
module psum_ram #(
    parameter int DEPTH = 36,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic          clk1,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk1) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulator: sums CI channel results per OFM pixel, emits saturated
// pixels on the last channel for each of CO filters. Define PSUM_RELU_EN to clamp
// negative final sums to zero before saturation.
//   state | meaning
//   IDLE  | waiting for start
//   ACCUM | accepting beats, in_ready high
//   FLUSH | two cycles draining the read/add/output pipeline
//   DONE  | one-cycle done pulse
module psum_accum
    import cnn_pkg::*;
#(
    parameter int IFM_SIZE    = 9,
    parameter int KERNEL_SIZE = 4,
    parameter int CI          = 3,
    parameter int CO          = 4,
    parameter int IN_W        = 24,
    parameter int ACC_W       = 32,
    parameter int OUT_W       = 16
) (
    input  logic                                         clk1,
    input  logic                                         rst_n,
    input  logic                                         start,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [IN_W-1:0]                              in_data,
    input  logic [$clog2(IFM_SIZE-KERNEL_SIZE+1):0]      in_x,
    input  logic [$clog2(IFM_SIZE-KERNEL_SIZE+1):0]      in_y,
    output logic                                         out_valid,
    output logic [OUT_W-1:0]                             out_data,
    output logic [$clog2(IFM_SIZE-KERNEL_SIZE+1):0]      out_x,
    output logic [$clog2(IFM_SIZE-KERNEL_SIZE+1):0]      out_y,
    output logic [$clog2(CO):0]                          out_f,
    output logic                                         done
);

    localparam int OFM  = ofm_size(IFM_SIZE, KERNEL_SIZE);
    localparam int NPIX = OFM * OFM;
    localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CW   = $clog2(OFM) + 1;
    localparam int FW   = $clog2(CO) + 1;
    localparam int CHW  = $clog2(CI) + 1;

    state_t           state;
    logic [AW-1:0]    pix_cnt;
    logic [CHW-1:0]   ch_cnt;
    logic [FW-1:0]    f_cnt;
    logic [1:0]       flush_tmr;

    logic             accept;
    logic [AW-1:0]    rd_idx;

    logic             s1_valid;
    logic             s1_first;
    logic             s1_last;
    logic [AW-1:0]    s1_idx;
    logic [CW-1:0]    s1_x;
    logic [CW-1:0]    s1_y;
    logic [FW-1:0]    s1_f;
    logic signed [ACC_W-1:0] s1_data;

    logic             fwd_hit;
    logic signed [ACC_W-1:0] fwd_data;
    logic signed [ACC_W-1:0] ram_rd;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] final_sum;
    logic             wr_en;

    assign accept = in_valid && in_ready;
    assign rd_idx = AW'(in_y * OFM + in_x);
    assign wr_en  = s1_valid && !s1_last;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            ch_cnt    <= '0;
            f_cnt     <= '0;
            flush_tmr <= '0;
            in_ready  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        in_ready <= 1'b1;
                        pix_cnt  <= '0;
                        ch_cnt   <= '0;
                        f_cnt    <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (pix_cnt == AW'(NPIX - 1)) begin
                            pix_cnt <= '0;
                            if (ch_cnt == CHW'(CI - 1)) begin
                                state     <= FLUSH;
                                in_ready  <= 1'b0;
                                flush_tmr <= 2'(FLUSH_LEN - 1);
                            end else begin
                                ch_cnt <= ch_cnt + 1'b1;
                            end
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_tmr == 2'd0) begin
                        f_cnt <= f_cnt + 1'b1;
                        if (f_cnt == FW'(CO - 1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            ch_cnt   <= '0;
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        flush_tmr <= flush_tmr - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    psum_ram #(
        .DEPTH (NPIX),
        .AW    (AW),
        .DW    (ACC_W)
    ) u_ram (
        .clk1    (clk1),
        .wr_en   (wr_en),
        .wr_addr (s1_idx),
        .wr_data (sum),
        .rd_en   (accept),
        .rd_addr (rd_idx),
        .rd_data (ram_rd)
    );

    always_comb begin
        base = '0;
        if (!s1_first) base = fwd_hit ? fwd_data : ram_rd;
        sum       = base + s1_data;
        final_sum = sum;
`ifdef PSUM_RELU_EN
        if (sum < 0) final_sum = '0;
`endif
    end

    // A read issued in the same cycle as a write to the same index sees stale RAM data.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_idx    <= '0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_f      <= '0;
            s1_data   <= '0;
            fwd_hit   <= 1'b0;
            fwd_data  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_f     <= '0;
        end else begin
            s1_valid <= accept;
            s1_first <= (ch_cnt == '0);
            s1_last  <= (ch_cnt == CHW'(CI - 1));
            s1_idx   <= rd_idx;
            s1_x     <= in_x;
            s1_y     <= in_y;
            s1_f     <= f_cnt;
            s1_data  <= {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};
            fwd_hit  <= accept && wr_en && (s1_idx == rd_idx);
            fwd_data <= sum;

            out_valid <= s1_valid && s1_last;
            if (s1_valid && s1_last) begin
                out_data <= OUT_W'(saturate(64'(final_sum), OUT_W));
                out_x    <= s1_x;
                out_y    <= s1_y;
                out_f    <= s1_f;
            end
        end
    end

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: default-size instance plus a 1x1 OFM, CI=2
// instance for back-to-back same-index accumulation.
module tb_psum_accum;

    logic clk1 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk1 = ~clk1;

    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = '0;
    logic [3:0]  in_x = '0;
    logic [3:0]  in_y = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [3:0]  out_x;
    logic [3:0]  out_y;
    logic [2:0]  out_f;
    logic        done;

    logic        s_start = 1'b0;
    logic        s_in_valid = 1'b0;
    logic [23:0] s_in_data = '0;
    logic [0:0]  s_in_x = '0;
    logic [0:0]  s_in_y = '0;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [15:0] s_out_data;
    logic [0:0]  s_out_x;
    logic [0:0]  s_out_y;
    logic [0:0]  s_out_f;
    logic        s_done;

    psum_accum u_dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_data(out_data), .out_x(out_x), .out_y(out_y),
        .out_f(out_f), .done(done)
    );

    psum_accum #(.IFM_SIZE(4), .KERNEL_SIZE(4), .CI(2), .CO(1)) u_small (
        .clk1(clk1), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .in_data(s_in_data), .in_x(s_in_x), .in_y(s_in_y),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_x(s_out_x), .out_y(s_out_y),
        .out_f(s_out_f), .done(s_done)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int beat_cyc = 0;
    int p25_beat_cyc = 0;

    int out_cnt = 0, bad_cnt = 0, done_cnt = 0, done_cyc = 0;
    int p25_val = 0, p25_cyc = 0;
    int f_hist[4] = '{0, 0, 0, 0};
    int exp_tab[4][36];

    always @(posedge clk1) cyc++;

    always @(negedge clk1) begin : monitor
        int seq;
        if (out_valid) begin
            seq = out_cnt % 36;
            if (int'(out_f) > 3 || int'(out_f) != (out_cnt / 36) % 4 ||
                int'(out_x) != seq % 6 || int'(out_y) != seq / 6)
                bad_cnt++;
            else if (int'($signed(out_data)) != exp_tab[int'(out_f)][seq])
                bad_cnt++;
            if (int'(out_f) < 4) f_hist[int'(out_f)]++;
            if (out_x == 4'd2 && out_y == 4'd5 && out_f == 3'd0) begin
                p25_val = int'($signed(out_data));
                p25_cyc = cyc;
            end
            out_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic send(input int x, input int y, input int d);
        int guard;
        guard = 0;
        in_x = 4'(x);
        in_y = 4'(y);
        in_data = 24'(d);
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk1);
            guard++;
        end
        if (guard >= 50) begin
            fails++;
            $display("FAIL send_timeout: observed in_ready %0b expected 1", in_ready);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1, "in_ready never rose");
        end
        beat_cyc = cyc;
        @(negedge clk1);
    endtask

    function automatic int beat_val(input int f, input int ch, input int idx, input int mode);
        if (mode == 2) return 2;
        if (f == 0 && idx == 32) return (ch == 0) ? 100 : (ch == 1) ? -50 : 7;
        if (f == 1 && idx == 0) return 20000;
        if (f == 1 && idx == 1) return -20000;
        return 1;
    endfunction

    task automatic run_conv(input int mode);
        for (int f = 0; f < 4; f++)
            for (int ch = 0; ch < 3; ch++)
                for (int idx = 0; idx < 36; idx++) begin
                    start = (mode == 1 && f == 0 && ch == 1 && idx == 10);
                    send(idx % 6, idx / 6, beat_val(f, ch, idx, mode));
                    start = 1'b0;
                    if (f == 0 && ch == 2 && idx == 32) p25_beat_cyc = beat_cyc;
                end
    endtask

    task automatic wait_done(input int base_done);
        int g;
        g = 0;
        while (done_cnt == base_done && g < 20) begin
            @(negedge clk1);
            g++;
        end
    endtask

    task automatic small_pair(input int a, input int b, input int exp_v, input string tag);
        int g;
        s_start = 1'b1;
        @(negedge clk1);
        s_start = 1'b0;
        s_in_valid = 1'b1;
        s_in_data = 24'(a);
        g = 0;
        while (s_in_ready !== 1'b1 && g < 10) begin
            @(negedge clk1);
            g++;
        end
        @(negedge clk1);
        s_in_data = 24'(b);
        @(negedge clk1);
        s_in_valid = 1'b0;
        g = 0;
        while (s_out_valid !== 1'b1 && g < 10) begin
            @(negedge clk1);
            g++;
        end
        check({tag, "_latency"}, g, 1);
        check({tag, "_data"}, int'($signed(s_out_data)), exp_v);
        g = 0;
        while (s_done !== 1'b1 && g < 10) begin
            @(negedge clk1);
            g++;
        end
        check({tag, "_done"}, int'(s_done), 1);
        @(negedge clk1);
    endtask

    initial begin : main
        int b_out, b_bad, b_done;
        int b_hist[4];

        repeat (3) @(negedge clk1);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_x", int'(out_x), 0);
        check("rst_out_y", int'(out_y), 0);
        check("rst_out_f", int'(out_f), 0);
        rst_n = 1'b1;
        @(negedge clk1);

        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 36; i++) exp_tab[f][i] = 3;
        exp_tab[0][32] = 57;
        exp_tab[1][0] = 32767;
`ifdef PSUM_RELU_EN
        exp_tab[1][1] = 0;
`else
        exp_tab[1][1] = -32768;
`endif

        b_out = out_cnt; b_bad = bad_cnt; b_done = done_cnt;
        for (int f = 0; f < 4; f++) b_hist[f] = f_hist[f];
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        run_conv(1);
        wait_done(b_done);
        repeat (5) @(negedge clk1);
        check("idle_in_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk1);
        check("conv1_out_count", out_cnt - b_out, 144);
        for (int f = 0; f < 4; f++) check("conv1_f_hist", f_hist[f] - b_hist[f], 36);
        check("conv1_bad_pixels", bad_cnt - b_bad, 0);
        check("conv1_done_count", done_cnt - b_done, 1);
        check("conv1_done_latency", done_cyc - beat_cyc, 3);
        check("pix25_value", p25_val, 57);
        check("pix25_latency", p25_cyc - p25_beat_cyc, 2);

        b_out = out_cnt; b_done = done_cnt;
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        for (int ch = 0; ch < 2; ch++)
            for (int idx = 0; idx < 36; idx++)
                if (ch == 0 || idx < 10) send(idx % 6, idx / 6, 50);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk1);
        rst_n = 1'b1;
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_out_valid", int'(out_valid), 0);
        repeat (5) @(negedge clk1);
        check("abort_no_done", done_cnt - b_done, 0);
        check("abort_no_output", out_cnt - b_out, 0);

        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 36; i++) exp_tab[f][i] = 6;
        b_out = out_cnt; b_bad = bad_cnt; b_done = done_cnt;
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        run_conv(2);
        wait_done(b_done);
        in_valid = 1'b0;
        repeat (3) @(negedge clk1);
        check("conv3_out_count", out_cnt - b_out, 144);
        check("conv3_bad_pixels", bad_cnt - b_bad, 0);
        check("conv3_done_count", done_cnt - b_done, 1);

        small_pair(5, 9, 14, "fwd_5_9");
        small_pair(-3, 10, 7, "fwd_m3_10");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
